// File: rtl/light_seq_fsm.sv
// light_seq_fsm: multi-channel light sequencer with per-channel saturating
// blink speed. Walks OFF_IDLE, ON, then a GAP/FLASH pair per channel, one step
// per `next` pulse, and owns the blink divider so `light` drives the LED.
// Optional auto-run (dwell-timed stepping) is enabled by the macro
// LIGHT_SEQ_AUTO_EN, which adds the `auto_run` input.
module light_seq_fsm #(
  parameter int NUM_CHANNELS  = 2,
  parameter int LEVELS        = 4,
  parameter int DEFAULT_LEVEL = 0,
  parameter int UNIT_CYCLES   = 50_000_000,
  parameter int AUTO_DWELL    = 200_000_000,
  localparam int STEP_W = $clog2(2 * NUM_CHANNELS + 2),
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next,
  input  logic              faster,
  input  logic              slower,
`ifdef LIGHT_SEQ_AUTO_EN
  input  logic              auto_run,
`endif
  output logic [STEP_W-1:0] step,
  output logic [CH_W-1:0]   chan,
  output logic [LVL_W-1:0]  level,
  output logic              light,
  output logic              tick,
  output logic              speed_up,
  output logic              slow_down
);

  // Width that holds the longest half-period minus one.
  localparam int CNT_W = $clog2(UNIT_CYCLES) + LEVELS - 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * NUM_CHANNELS + 1);
  localparam logic [LVL_W-1:0]  MAX_LVL   = LVL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0]  UNIT_C    = CNT_W'(UNIT_CYCLES);

  typedef enum logic [1:0] {
    S_OFF,    // OFF_IDLE, step 0
    S_ON,     // steady on, step 1
    S_GAP,    // dark gap before a channel's flash
    S_FLASH   // blinking at the channel's level
  } phase_t;

  // Reject out-of-range configurations at elaboration.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || LEVELS < 2 || LEVELS > 8 ||
      DEFAULT_LEVEL < 0 || DEFAULT_LEVEL >= LEVELS || UNIT_CYCLES < 2 ||
      AUTO_DWELL < 1) begin : g_bad_params
    $error("light_seq_fsm: parameter out of range");
  end

  phase_t            phase;
  phase_t            nxt_phase;
  logic [STEP_W-1:0] nxt_step;
  logic [CH_W-1:0]   nxt_chan;
  logic [LVL_W-1:0]  lvls [NUM_CHANNELS];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  term;
  logic              adv;

  // Terminal count of the active half-period; wraps cleanly when the
  // half-period is exactly 2**CNT_W.
  assign term = (UNIT_C << level) - CNT_W'(1);

`ifdef LIGHT_SEQ_AUTO_EN
  localparam int DW_W = (AUTO_DWELL > 1) ? $clog2(AUTO_DWELL) : 1;

  logic [DW_W-1:0] dwell;
  logic            dwell_exp;

  assign dwell_exp = auto_run && (dwell == DW_W'(AUTO_DWELL - 1));
  // A coincident external next and dwell expiry still advance only once.
  assign adv = next || dwell_exp;

  // Dwell timer: restarts on any advance, on auto_run low and on reset.
  always_ff @(posedge clk) begin
    if (!reset || !auto_run || next || dwell_exp) dwell <= '0;
    else                                          dwell <= dwell + DW_W'(1);
  end
`else
  assign adv = next;
`endif

  // Successor step, phase and channel for an advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    nxt_step  = step + STEP_W'(1);
    nxt_phase = phase;
    nxt_chan  = chan;
    if (step == LAST_STEP) begin
      nxt_step  = '0;
      nxt_phase = S_OFF;
      nxt_chan  = '0;
    end else begin
      case (phase)
        S_OFF:   nxt_phase = S_ON;
        S_ON:    nxt_phase = S_GAP;
        S_GAP:   nxt_phase = S_FLASH;
        S_FLASH: begin
          nxt_phase = S_GAP;
          nxt_chan  = chan + CH_W'(1);
        end
        default: nxt_phase = S_OFF;
      endcase
    end
  end

  // Sequencer, level store, blink divider and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      phase     <= S_OFF;
      step      <= '0;
      chan      <= '0;
      level     <= '0;
      light     <= 1'b0;
      tick      <= 1'b0;
      speed_up  <= 1'b0;
      slow_down <= 1'b0;
      cnt       <= '0;
      // NOTE: the level array is a handful of flops whose reset value is
      // architecturally visible, so it is reset like any other state.
      for (int i = 0; i < NUM_CHANNELS; i++) lvls[i] <= LVL_W'(DEFAULT_LEVEL);
    end else begin
      tick      <= 1'b0;
      speed_up  <= 1'b0;
      slow_down <= 1'b0;
      if (adv) begin
        phase <= nxt_phase;
        step  <= nxt_step;
        chan  <= nxt_chan;
        cnt   <= '0;
        level <= (nxt_phase == S_GAP || nxt_phase == S_FLASH) ? lvls[nxt_chan] : '0;
        light <= (nxt_phase == S_ON || nxt_phase == S_FLASH);
      end else if (phase == S_FLASH) begin
        if (faster && !slower && level != '0) begin
          lvls[chan] <= level - LVL_W'(1);
          level      <= level - LVL_W'(1);
          cnt        <= '0;
          speed_up   <= 1'b1;
        end else if (slower && !faster && level != MAX_LVL) begin
          lvls[chan] <= level + LVL_W'(1);
          level      <= level + LVL_W'(1);
          cnt        <= '0;
          slow_down  <= 1'b1;
        end else if (cnt == term) begin
          cnt   <= '0;
          light <= ~light;
          tick  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_light_seq_fsm.sv
// tb_light_seq_fsm: directed plus randomized bench for light_seq_fsm. A
// behavioural model tracks step index, per-channel levels and the elapsed time
// since the last blink event; every cycle's outputs are compared against it.
// Build with LIGHT_SEQ_AUTO_EN defined to also exercise auto-run.
module tb_light_seq_fsm;

  localparam int NCH    = 2;
  localparam int NLVL   = 4;
  localparam int DEFLVL = 0;
  localparam int UNIT   = 4;
  localparam int DWELL  = 10;
  localparam int NSTEPS = 2 * NCH + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       next = 1'b0;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       auto_run = 1'b0;
  logic [2:0] step;
  logic [0:0] chan;
  logic [1:0] level;
  logic       light;
  logic       tick;
  logic       speed_up;
  logic       slow_down;

  int n_checks = 0;
  int n_fail   = 0;

  light_seq_fsm #(
    .NUM_CHANNELS (NCH),
    .LEVELS       (NLVL),
    .DEFAULT_LEVEL(DEFLVL),
    .UNIT_CYCLES  (UNIT),
    .AUTO_DWELL   (DWELL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .next     (next),
    .faster   (faster),
    .slower   (slower),
`ifdef LIGHT_SEQ_AUTO_EN
    .auto_run (auto_run),
`endif
    .step     (step),
    .chan     (chan),
    .level    (level),
    .light    (light),
    .tick     (tick),
    .speed_up (speed_up),
    .slow_down(slow_down)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not complete, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model state.
  int m_step, m_light, m_tick, m_su, m_sd, m_elapsed, m_since;
  int m_lvl [NCH];

  function automatic bit is_flash(input int s);
    return (s >= 3) && (s % 2 == 1);
  endfunction

  function automatic int m_chan();
    return (m_step >= 2) ? (m_step - 2) / 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit n, input bit f, input bit s, input bit a);
    bit adv;
    if (!r) begin
      m_step = 0; m_light = 0; m_tick = 0; m_su = 0; m_sd = 0;
      m_elapsed = 0; m_since = 0;
      foreach (m_lvl[i]) m_lvl[i] = DEFLVL;
      return;
    end
    m_tick = 0; m_su = 0; m_sd = 0;
    adv = n;
    if (!a) m_since = 0;
    else begin
      m_since++;
      if (n || m_since == DWELL) begin
        adv = 1'b1;
        m_since = 0;
      end
    end
    if (adv) begin
      m_step    = (m_step + 1) % NSTEPS;
      m_light   = (m_step == 1 || is_flash(m_step)) ? 1 : 0;
      m_elapsed = 0;
    end else if (is_flash(m_step)) begin
      int c = m_chan();
      if (f && !s && m_lvl[c] > 0) begin
        m_lvl[c]--; m_su = 1; m_elapsed = 0;
      end else if (s && !f && m_lvl[c] < NLVL - 1) begin
        m_lvl[c]++; m_sd = 1; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == (UNIT << m_lvl[c])) begin
          m_light = 1 - m_light; m_tick = 1; m_elapsed = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cyc(input bit r, input bit n, input bit f, input bit s);
    reset = r; next = n; faster = f; slower = s;
    @(posedge clk);
    model_edge(r, n, f, s, auto_run);
    #1;
    check("step",      32'(step),      32'(m_step));
    check("chan",      32'(chan),      32'(m_chan()));
    check("level",     32'(level),     32'((m_step >= 2) ? m_lvl[m_chan()] : 0));
    check("light",     32'(light),     32'(m_light));
    check("tick",      32'(tick),      32'(m_tick));
    check("speed_up",  32'(speed_up),  32'(m_su));
    check("slow_down", 32'(slow_down), 32'(m_sd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_step [6] = '{1, 2, 3, 4, 5, 0};
    int exp_lit  [6] = '{1, 0, 1, 0, 1, 0};
    int exp_chan [6] = '{0, 0, 0, 1, 1, 0};
    int exp_lvl3 [4] = '{1, 2, 3, 3};
    int strobes, nticks, t0, t1, ncyc;

    // Reset and idle.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    idle(2);

    // Walk the full sequence once.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("seq_step",  32'(step),  32'(exp_step[i]));
      check("seq_light", 32'(light), 32'(exp_lit[i]));
      check("seq_chan",  32'(chan),  32'(exp_chan[i]));
      idle(2);
    end

    // Speed pulses in OFF_IDLE are ignored.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("idle_fast_su", 32'(speed_up), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("idle_slow_sd", 32'(slow_down), 32'd0);
    check("idle_step", 32'(step), 32'd0);
    check("idle_level", 32'(level), 32'd0);

    // Into FLASH_0 and slow it down to saturation.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("flash0_step", 32'(step), 32'd3);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      strobes += int'(slow_down);
      check("slow_level", 32'(level), 32'(exp_lvl3[i]));
      idle(1);
    end
    check("slow_strobes", 32'(strobes), 32'd3);

    // Tick spacing at level 3, bounded search.
    nticks = 0; t0 = 0; t1 = 0; ncyc = 0;
    for (int i = 0; i < 100 && nticks < 2; i++) begin
      idle(1);
      ncyc++;
      if (tick === 1'b1) begin
        if (nticks == 0) t0 = ncyc; else t1 = ncyc;
        nticks++;
      end
    end
    check("ticks_seen", 32'(nticks), 32'd2);
    check("tick_spacing", 32'(t1 - t0), 32'd32);

    // Faster, then next and faster together.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("fast_level", 32'(level), 32'd2);
    check("fast_su", 32'(speed_up), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("nf_step", 32'(step), 32'd4);
    check("nf_level", 32'(level), 32'd0);
    check("nf_su", 32'(speed_up), 32'd0);

    // Around to FLASH_0: level retained, then reset mid-blink.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("wrap_step", 32'(step), 32'd3);
    check("wrap_level", 32'(level), 32'd2);
    idle(13);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_step", 32'(step), 32'd0);
    check("abort_light", 32'(light), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("deflvl", 32'(level), 32'(DEFLVL));

`ifdef LIGHT_SEQ_AUTO_EN
    // Auto-run: one step per DWELL cycles; coincident next advances once.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    auto_run = 1'b1;
    idle(30);
    check("auto_step", 32'(step), 32'd3);
    idle(9);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("auto_coinc", 32'(step), 32'd4);
    idle(5);
    auto_run = 1'b0;
    idle(12);
    check("auto_off", 32'(step), 32'd4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, n, f, s;
      r = ($urandom_range(499) != 0);
      n = ($urandom_range(39) == 0);
      f = ($urandom_range(9) == 0);
      s = ($urandom_range(7) == 0);
`ifdef LIGHT_SEQ_AUTO_EN
      if ($urandom_range(199) == 0) auto_run = ~auto_run;
`endif
      cyc(r, n, f, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_seq_fsm.md
# light_seq_fsm

Parametrised successor to the lab 3 master light controller. It steps through OFF, ON and then an OFF/FLASH pair for each of `NUM_CHANNELS` flash channels, one step per `next` pulse. Each flash channel keeps its own saturating speed level, and the block owns the blink divider, so it drives the LED directly. It sits between the debounced, one-pulsed button inputs and the LED output.

## Interface

**Parameters**
- `NUM_CHANNELS`, 2: number of flash channels (1..8).
- `LEVELS`, 4: speed levels per channel (2..8). Level 0 is fastest.
- `DEFAULT_LEVEL`, 0: reset level of every channel (< `LEVELS`).
- `UNIT_CYCLES`, 50_000_000: blink half-period at level 0, in clk cycles (≥ 2).
- `AUTO_DWELL`, 200_000_000: clk cycles per step in auto-run. Used only with the configuration macro.

**Ports**
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low.
- `next` in 1: single-cycle pulse; advance one step.
- `faster` in 1: single-cycle pulse; decrement the active channel's level.
- `slower` in 1: single-cycle pulse; increment the active channel's level.
- `step` out STEP_W = clog2(2·NUM_CHANNELS+2): current step index.
- `chan` out CH_W = max(1, clog2(NUM_CHANNELS)): active channel.
- `level` out LVL_W = max(1, clog2(LEVELS)): active channel's level.
- `light` out 1: LED drive.
- `tick` out 1: one-cycle pulse on each blink toggle.
- `speed_up` out 1: one-cycle strobe when a level actually decreased.
- `slow_down` out 1: one-cycle strobe when a level actually increased.

## Operation

**Steps**
- Step 0 is OFF_IDLE. Step 1 is ON.
- Step 2+2i is GAP_i; step 3+2i is FLASH_i, for i = 0..NUM_CHANNELS−1.
- `next` advances `step` by one. From the last FLASH the step wraps to 0.

**Outputs by step**
- `chan` = i in GAP_i and FLASH_i; otherwise 0.
- `level` = level[i] in GAP_i and FLASH_i; otherwise 0.
- `light` = 0 in OFF_IDLE and GAP_i, 1 in ON, blinking in FLASH_i.

**Speed levels**
- `faster`/`slower` act only in FLASH_i, and only on level[i]. Other steps ignore them: no level change, no strobe.
- Levels saturate at 0 and at LEVELS−1. A pulse at the limit changes nothing and raises no strobe.
- Levels persist across steps and wraps. Only `reset` restores them to DEFAULT_LEVEL.

**Input priority (same cycle)**
- `next` wins: the step advances and `faster`/`slower` are ignored.
- `faster` and `slower` together (no `next`): no change.

**Blink divider**
- Half-period is UNIT_CYCLES << level[i].
- Counter width is clog2(UNIT_CYCLES) + LEVELS − 1.
- On the half-period terminal count, `light` toggles, `tick` pulses and the counter clears.

## Timing

**Reset**
- The cycle after `reset` is sampled low: `step`=0, `chan`=0, `level`=0, `light`=0, `tick`=0, `speed_up`=0, `slow_down`=0, counter=0, and all level[] = DEFAULT_LEVEL.
- `reset` low mid-flash aborts immediately. It overrides every input in the same cycle.

**Latency**
- All outputs are registered with one-cycle latency. An input pulse sampled at edge k is visible after edge k.
- Strobes are high for exactly the cycle after the accepted pulse.

**Entering FLASH_i**
- `light`=1 and the counter is cleared.
- The first toggle occurs UNIT_CYCLES<<level[i] cycles after entry.

**Level change inside FLASH_i**
- The counter clears and `light` holds its current phase.
- The next toggle follows the new half-period.

**Leaving FLASH_i**
- The counter clears, `tick` stays 0, and `light` follows the new step in the same cycle.

## Configuration

Macro: `LIGHT_SEQ_AUTO_EN`.

**Defined**
- Adds input `auto_run` (1 bit).
- While `auto_run`=1, a dwell counter generates an internal `next` every AUTO_DWELL cycles.
- The dwell counter clears on any external `next`, on `auto_run` falling, and on `reset`.
- An external `next` in the same cycle as a dwell expiry advances the step exactly once.

**Undefined**
- No `auto_run` port, no dwell counter. Steps advance only on `next`.

## Test plan

Bench parameters: NUM_CHANNELS=2, LEVELS=4, DEFAULT_LEVEL=0, UNIT_CYCLES=4.

1. Reset, then 6 `next` pulses → `step` goes 1,2,3,4,5,0. `light` goes 1,0,1(blinking),0,1(blinking),0. `chan` in steps 2..5 is 0,0,1,1.
2. In step 0 (OFF_IDLE): `faster`, then `slower` → `step` stays 0, `level` stays 0, no strobes.
3. In FLASH_0 (step 3): four `slower` pulses → `level` goes 1,2,3,3. `slow_down` strobes 3 times, not on the 4th pulse. At level 3, `tick` spacing is 32 cycles.
4. Then `faster` → `level`=2 with a `speed_up` strobe. Then `next` and `faster` in the same cycle → `step`=4, `level` = level[1] = 0, no strobe.
5. Go around the full sequence back to FLASH_0 → `level`=2 is retained. Assert `reset` low mid-blink → all outputs 0 on the next cycle and `level` = DEFAULT_LEVEL.
6. With `LIGHT_SEQ_AUTO_EN` and AUTO_DWELL=10: `auto_run`=1 → `step` advances every 10 cycles. An external `next` that coincides with a dwell expiry advances `step` by exactly 1.
